// File: rtl/mcac_pcm_tx.sv
// mcac_pcm_tx: PCM TDM frame transmitter driving the encoder's s/s_clk/s_fs input port.
// Revision: 1.0
`default_nettype none

module mcac_pcm_tx #(
  parameter int NCH   = 32,
  parameter int DIV   = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   law,
  input  logic [7:0]             in_data,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             s,
  output logic                   s_clk,
  output logic                   s_fs,
  output logic [$clog2(NCH)-1:0] ch_idx,
  output logic                   underrun,
  output logic                   sync_err
);

  localparam int CW = $clog2(NCH);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DIV);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          run_ok;
  logic          started;
  logic [DW-1:0] div_cnt;

  logic          full;
  logic          empty;
  logic [8:0]    head;
  logic          load;
  logic          push;
  logic          pop;
  logic          misaligned;
  logic [CW-1:0] nxt_ch;
  logic [DW-1:0] div_nxt;
  logic [7:0]    idle_code;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign in_ready  = run_ok && !full;
  assign push      = reset && in_valid && in_ready;
  assign load      = enable && (!started || div_cnt == DW'(DIV-1));
  assign idle_code = law ? 8'hD5 : 8'hFF;

  always_comb begin
    nxt_ch = '0;
    if (started && ch_idx != CW'(NCH-1))
      nxt_ch = ch_idx + 1'b1;
    div_nxt    = load ? '0 : div_cnt + 1'b1;
    // A start-of-frame sample is held back until slot 0 comes around.
    misaligned = head[8] && (nxt_ch != '0);
    pop        = load && !empty && !misaligned;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_sof, in_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      run_ok   <= 1'b0;
      started  <= 1'b0;
      div_cnt  <= '0;
      s        <= '0;
      s_clk    <= 1'b0;
      s_fs     <= 1'b0;
      ch_idx   <= '0;
      underrun <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      run_ok   <= 1'b1;
      underrun <= 1'b0;
      sync_err <= 1'b0;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;

      if (enable) begin
        started <= 1'b1;
        div_cnt <= div_nxt;
        s_clk   <= (div_nxt >= DW'(DIV/2));
        if (load) begin
          ch_idx <= nxt_ch;
          s_fs   <= (nxt_ch == '0);
          if (empty) begin
            s        <= idle_code;
            underrun <= 1'b1;
          end else if (misaligned) begin
            s        <= idle_code;
            sync_err <= 1'b1;
          end else begin
            s <= head[7:0];
          end
        end
      end else begin
        started <= 1'b0;
        div_cnt <= '0;
        s_clk   <= 1'b0;
        s_fs    <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mcac_pcm_tx.sv
// tb_mcac_pcm_tx: directed stimulus with a time-based frame model checked every cycle.
// Revision: 1.0
`default_nettype none

module tb_mcac_pcm_tx;

  localparam int NCH   = 4;
  localparam int DIV   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       law;
  logic [7:0] in_data;
  logic       in_sof;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] s;
  logic       s_clk;
  logic       s_fs;
  logic [1:0] ch_idx;
  logic       underrun;
  logic       sync_err;

  int n_cmp = 0;
  int n_bad = 0;

  mcac_pcm_tx #(.NCH(NCH), .DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .law(law),
    .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .s_clk(s_clk), .s_fs(s_fs), .ch_idx(ch_idx),
    .underrun(underrun), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Model: slot position derived from elapsed cycles since the start load.
  logic [8:0] q[$];
  bit         running = 0;
  bit         m_on = 0;
  bit         m_rdy = 0;
  int         t = 0;
  logic [7:0] m_s = 0;
  int         m_ch = 0;
  bit         m_fs = 0, m_sclk = 0, m_und = 0, m_serr = 0;

  task automatic do_load(input int n);
    logic [8:0] h;
    m_ch = n;
    m_fs = (n == 0);
    if (q.size() == 0) begin
      m_s   = law ? 8'hD5 : 8'hFF;
      m_und = 1;
    end else if (q[0][8] && n != 0) begin
      m_s    = law ? 8'hD5 : 8'hFF;
      m_serr = 1;
    end else begin
      h   = q.pop_front();
      m_s = h[7:0];
    end
  endtask

  always @(posedge clk) begin
    bit push;
    if (!reset) begin
      q.delete();
      running = 0; t = 0; m_s = 0; m_ch = 0;
      m_fs = 0; m_sclk = 0; m_und = 0; m_serr = 0; m_rdy = 0;
      m_on = 1;
    end else begin
      push   = in_valid && m_rdy && (q.size() < DEPTH);
      m_rdy  = 1;
      m_und  = 0;
      m_serr = 0;
      if (enable) begin
        if (!running) begin
          running = 1;
          t = 0;
          do_load(0);
        end else begin
          t++;
          if (t % DIV == 0) do_load((t / DIV) % NCH);
        end
        m_sclk = (t % DIV) >= DIV / 2;
      end else begin
        running = 0;
        m_sclk  = 0;
        m_fs    = 0;
      end
      if (push) q.push_back({in_sof, in_data});
    end
  end

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (m_on) begin
      cmp("s",        32'(s),        32'(m_s));
      cmp("s_clk",    32'(s_clk),    32'(m_sclk));
      cmp("s_fs",     32'(s_fs),     32'(m_fs));
      cmp("ch_idx",   32'(ch_idx),   32'(m_ch));
      cmp("underrun", 32'(underrun), 32'(m_und));
      cmp("sync_err", 32'(sync_err), 32'(m_serr));
      cmp("in_ready", 32'(in_ready), 32'(m_rdy && q.size() < DEPTH));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push1(input logic [7:0] d, input logic sof);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    step(1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  logic [7:0] exp_seq [4];

  initial begin
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;
    reset = 1'b0; enable = 1'b0; law = 1'b0;
    in_data = 8'h00; in_sof = 1'b0; in_valid = 1'b0;

    // Reset
    step(3);
    cmp("rst_s", 32'(s), 32'h0);
    cmp("rst_ready", 32'(in_ready), 32'h0);
    cmp("rst_sclk", 32'(s_clk), 32'h0);
    reset = 1'b1;
    step(1);
    cmp("ready_after_rst", 32'(in_ready), 32'h1);

    // Preload a frame, then run it out
    push1(8'h11, 1'b1);
    push1(8'h22, 1'b0);
    push1(8'h33, 1'b0);
    push1(8'h44, 1'b0);
    enable = 1'b1;
    step(1);
    for (int k = 0; k < 4; k++) begin
      cmp("seq_s", 32'(s), 32'(exp_seq[k]));
      cmp("seq_fs", 32'(s_fs), (k == 0) ? 32'h1 : 32'h0);
      cmp("seq_ch", 32'(ch_idx), 32'(k));
      step(4);
      cmp("seq_sclk_hi", 32'(s_clk), 32'h1);
      step(4);
    end

    // Underrun, mu-law then A-law
    cmp("und_s_mu", 32'(s), 32'hFF);
    cmp("und_pulse", 32'(underrun), 32'h1);
    law = 1'b1;
    step(8);
    cmp("und_s_a", 32'(s), 32'hD5);

    // Misaligned start-of-frame sample
    push1(8'hAA, 1'b1);
    step(7);
    cmp("sync_ch2_s", 32'(s), 32'hD5);
    cmp("sync_ch2_err", 32'(sync_err), 32'h1);
    step(8);
    cmp("sync_ch3_err", 32'(sync_err), 32'h1);
    step(8);
    cmp("sync_ch0_s", 32'(s), 32'hAA);
    cmp("sync_ch0_fs", 32'(s_fs), 32'h1);
    law = 1'b0;

    // Fill the FIFO; push while full is ignored
    push1(8'h01, 1'b0);
    push1(8'h02, 1'b0);
    push1(8'h03, 1'b0);
    push1(8'h04, 1'b0);
    cmp("full_ready", 32'(in_ready), 32'h0);
    push1(8'hEE, 1'b0);
    step(2);
    cmp("full_ready2", 32'(in_ready), 32'h0);
    step(1);
    cmp("pop_s01", 32'(s), 32'h01);
    cmp("pop_ready", 32'(in_ready), 32'h1);
    push1(8'h05, 1'b0);
    cmp("refill_ready", 32'(in_ready), 32'h0);
    step(7);
    cmp("pop_s02", 32'(s), 32'h02);
    step(7);
    in_valid = 1'b1; in_data = 8'h06;
    step(1);
    in_valid = 1'b0;
    cmp("pushpop_s03", 32'(s), 32'h03);
    cmp("pushpop_ready", 32'(in_ready), 32'h1);
    push1(8'h07, 1'b0);
    cmp("full_again", 32'(in_ready), 32'h0);
    step(7);
    cmp("s04", 32'(s), 32'h04);
    step(8);
    cmp("s05", 32'(s), 32'h05);
    step(8);
    cmp("s06", 32'(s), 32'h06);

    // Disable mid slot 2 while s_clk is high
    step(5);
    cmp("pre_dis_sclk", 32'(s_clk), 32'h1);
    enable = 1'b0;
    step(1);
    cmp("dis_sclk", 32'(s_clk), 32'h0);
    cmp("dis_s_hold", 32'(s), 32'h06);
    cmp("dis_ch_hold", 32'(ch_idx), 32'h2);
    push1(8'h08, 1'b0);
    step(8);
    enable = 1'b1;
    step(1);
    cmp("reen_s", 32'(s), 32'h07);
    cmp("reen_fs", 32'(s_fs), 32'h1);
    cmp("reen_ch", 32'(ch_idx), 32'h0);
    step(8);
    cmp("reen_s08", 32'(s), 32'h08);

    // Reset mid-frame
    push1(8'h09, 1'b0);
    step(2);
    reset = 1'b0;
    step(1);
    cmp("mid_rst_s", 32'(s), 32'h0);
    cmp("mid_rst_ch", 32'(ch_idx), 32'h0);
    cmp("mid_rst_ready", 32'(in_ready), 32'h0);
    reset = 1'b1;
    step(1);
    cmp("post_rst_s", 32'(s), 32'hFF);
    cmp("post_rst_und", 32'(underrun), 32'h1);
    cmp("post_rst_fs", 32'(s_fs), 32'h1);
    step(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
